// File: rtl/midi_rx_parser.sv
// -----------------------------------------------------------------------------
// midi_rx_parser
//   Serial MIDI front end. A 16x-oversampled UART receiver (8N1) feeds a
//   channel-voice message parser, and complete messages go into a small
//   first-word-fall-through event FIFO that the MMIO MIDI slot reads and pops.
//
// Parameters
//   CLK_FREQ  system clock in Hz
//   BAUD      MIDI bit rate; one 16x tick every CLK_FREQ/(BAUD*16) clocks
//   FIFO_AW   event FIFO address width (depth 2**FIFO_AW)
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   midi_in    raw MIDI line, idle high, asynchronous to clk
//   rd         pop the head event (single-cycle pulse)
//   clr_err    clear the ovf / frame_err sticky flags
//   ev_valid   FIFO not empty; ev_* carry the head event
//   ev_status  status byte of the head event
//   ev_data1   first data byte
//   ev_data2   second data byte (0 for one-data-byte messages)
//   ovf        sticky: an event was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
//
// Configuration
//   MIDI_RUNNING_STATUS_EN  when defined, the status byte stays latched after
//                           a complete message so further data bytes form new
//                           events with the same status.
// -----------------------------------------------------------------------------
module midi_rx_parser #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 31_250,
   parameter int FIFO_AW  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       midi_in,
   input  logic       rd,
   input  logic       clr_err,
   output logic       ev_valid,
   output logic [7:0] ev_status,
   output logic [6:0] ev_data1,
   output logic [6:0] ev_data2,
   output logic       ovf,
   output logic       frame_err
);

   localparam int DVSR  = CLK_FREQ / (BAUD * 16);
   localparam int TW    = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_e;

   typedef struct packed {
      logic [7:0] status;
      logic [6:0] d1;
      logic [6:0] d2;
   } midi_ev_t;

   // ---------------------------------------------------------------- state
   logic [1:0]       sync_q;
   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   rx_state_e        state_q, state_d;
   logic [3:0]       s_cnt_q, s_cnt_d;
   logic [2:0]       n_cnt_q, n_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             byte_rdy_q, byte_rdy_d;
   logic [7:0]       stat_q, stat_d;
   logic             stat_vld_q, stat_vld_d;
   logic             need2_q, need2_d;
   logic             have1_q, have1_d;
   logic [6:0]       d1_q, d1_d;
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic             ovf_q, ovf_d;
   logic             frame_err_q, frame_err_d;
   midi_ev_t         mem_q [DEPTH];

   logic     rx_s;
   logic     tick;
   logic     frame_set;
   logic     push;
   midi_ev_t push_ev;
   logic     empty, full, do_wr, do_rd, ovf_set;
   midi_ev_t head;

   assign rx_s = sync_q[1];

   // Free-running 16x tick; the receiver is phase-agnostic and re-centres
   // on each start bit by counting 8 ticks.
   always_comb begin
      tick       = (tick_cnt_q == TW'(DVSR - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   // ---------------------------------------------------------------- RX FSM
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      s_cnt_d    = s_cnt_q;
      n_cnt_d    = n_cnt_q;
      shreg_d    = shreg_q;
      byte_rdy_d = 1'b0;
      frame_set  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               s_cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (s_cnt_q == 4'd7) begin
                  // Mid start bit: a high line means the falling edge was a glitch.
                  s_cnt_d = '0;
                  n_cnt_d = '0;
                  state_d = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_cnt_q == 4'd15) begin
                  s_cnt_d = '0;
                  shreg_d = {rx_s, shreg_q[7:1]};  // LSB first
                  if (n_cnt_q == 3'd7) state_d = ST_STOP;
                  else                 n_cnt_d = n_cnt_q + 3'd1;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (s_cnt_q == 4'd15) begin
                  state_d = ST_IDLE;
                  if (rx_s) byte_rdy_d = 1'b1;
                  else      frame_set  = 1'b1;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- parser
   always_comb begin
      stat_d         = stat_q;
      stat_vld_d     = stat_vld_q;
      need2_d        = need2_q;
      have1_d        = have1_q;
      d1_d           = d1_q;
      push           = 1'b0;
      push_ev.status = stat_q;
      push_ev.d1     = d1_q;
      push_ev.d2     = 7'd0;
      // Real-time bytes (F8-FF) fall through untouched so they can sit
      // anywhere inside a message.
      if (byte_rdy_q && shreg_q[7:3] != 5'b11111) begin
         if (shreg_q[7:4] == 4'hF) begin
            stat_vld_d = 1'b0;
            have1_d    = 1'b0;
         end else if (shreg_q[7]) begin
            stat_d     = shreg_q;
            stat_vld_d = 1'b1;
            have1_d    = 1'b0;
            need2_d    = (shreg_q[7:5] != 3'b110);  // C0-DF carry one data byte
         end else if (stat_vld_q) begin
            if (need2_q && !have1_q) begin
               d1_d    = shreg_q[6:0];
               have1_d = 1'b1;
            end else begin
               push    = 1'b1;
               have1_d = 1'b0;
               if (need2_q) push_ev.d2 = shreg_q[6:0];
               else         push_ev.d1 = shreg_q[6:0];
`ifdef MIDI_RUNNING_STATUS_EN
               stat_vld_d = stat_vld_q;
`else
               stat_vld_d = 1'b0;
`endif
            end
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      do_rd   = rd && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_wr   = push && (!full || rd);
      ovf_set = push && full && !rd;
      wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, do_wr};
      rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, do_rd};
      // Set wins over clear when both land in the same cycle.
      ovf_d       = (ovf_q & ~clr_err) | ovf_set;
      frame_err_d = (frame_err_q & ~clr_err) | frame_set;
      head        = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   end

   // NOTE: the event storage has no reset; it is only read through ev_valid
   // gating, so clearing it would cost reset routing for nothing.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_ev;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q      <= 2'b11;
         tick_cnt_q  <= '0;
         state_q     <= ST_IDLE;
         s_cnt_q     <= '0;
         n_cnt_q     <= '0;
         shreg_q     <= '0;
         byte_rdy_q  <= 1'b0;
         stat_q      <= '0;
         stat_vld_q  <= 1'b0;
         need2_q     <= 1'b0;
         have1_q     <= 1'b0;
         d1_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ovf_q       <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], midi_in};
         tick_cnt_q  <= tick_cnt_d;
         state_q     <= state_d;
         s_cnt_q     <= s_cnt_d;
         n_cnt_q     <= n_cnt_d;
         shreg_q     <= shreg_d;
         byte_rdy_q  <= byte_rdy_d;
         stat_q      <= stat_d;
         stat_vld_q  <= stat_vld_d;
         need2_q     <= need2_d;
         have1_q     <= have1_d;
         d1_q        <= d1_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ovf_q       <= ovf_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign ev_valid  = !empty;
   assign ev_status = empty ? 8'd0 : head.status;
   assign ev_data1  = empty ? 7'd0 : head.d1;
   assign ev_data2  = empty ? 7'd0 : head.d2;
   assign ovf       = ovf_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_midi_rx_parser
//   Directed bench for midi_rx_parser. The clock frequency parameter is scaled
//   so one 16x tick is 4 clocks and one MIDI bit is 64 clocks.
// -----------------------------------------------------------------------------
module tb_midi_rx_parser;

   localparam int BAUD     = 31_250;
   localparam int CLK_FREQ = BAUD * 16 * 4;
   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       midi_in;
   logic       rd;
   logic       clr_err;
   logic       ev_valid;
   logic [7:0] ev_status;
   logic [6:0] ev_data1;
   logic [6:0] ev_data2;
   logic       ovf;
   logic       frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   midi_rx_parser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .midi_in   (midi_in),
      .rd        (rd),
      .clr_err   (clr_err),
      .ev_valid  (ev_valid),
      .ev_status (ev_status),
      .ev_data1  (ev_data1),
      .ev_data2  (ev_data2),
      .ovf       (ovf),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame. A bad stop bit is held low only long enough to be
   // sampled, then the line returns high so no new frame is started.
   task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
      midi_in = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         midi_in = b[i];
         wait_clks(BIT_CLKS);
      end
      if (bad_stop) begin
         midi_in = 1'b0;
         wait_clks(48);
         midi_in = 1'b1;
         wait_clks(2 * BIT_CLKS);
      end else begin
         midi_in = 1'b1;
         wait_clks(BIT_CLKS + 16);
      end
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_byte(a);
      send_byte(b);
      send_byte(c);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] s,
                            input logic [6:0] d1, input logic [6:0] d2);
      check({tag, ".valid"},  {31'd0, ev_valid}, 32'd1);
      check({tag, ".status"}, {24'd0, ev_status}, {24'd0, s});
      check({tag, ".d1"},     {25'd0, ev_data1}, {25'd0, d1});
      check({tag, ".d2"},     {25'd0, ev_data2}, {25'd0, d2});
      rd = 1'b1;
      wait_clks(1);
      rd = 1'b0;
   endtask

   task automatic expect_empty(input string tag);
      check(tag, {31'd0, ev_valid}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      midi_in = 1'b1;
      rd      = 1'b0;
      clr_err = 1'b0;
      wait_clks(3);
      check("reset.valid",  {31'd0, ev_valid}, 32'd0);
      check("reset.status", {24'd0, ev_status}, 32'd0);
      check("reset.ovf",    {31'd0, ovf}, 32'd0);
      check("reset.ferr",   {31'd0, frame_err}, 32'd0);
      reset_n = 1'b1;
      wait_clks(20);

      // Basic note-on.
      send3(8'h90, 8'h3C, 8'h64);
      pop_check("note_on", 8'h90, 7'h3C, 7'h64);
      expect_empty("note_on.popped");

      // Running status on vs off.
      send3(8'h90, 8'h3C, 8'h64);
      send_byte(8'h3E);
      send_byte(8'h00);
      pop_check("rs.first", 8'h90, 7'h3C, 7'h64);
`ifdef MIDI_RUNNING_STATUS_EN
      pop_check("rs.second", 8'h90, 7'h3E, 7'h00);
`endif
      expect_empty("rs.done");

      // Program change: one data byte, d2 forced to 0.
      send_byte(8'hC5);
      send_byte(8'h07);
      pop_check("prog_chg", 8'hC5, 7'h07, 7'h00);
      expect_empty("prog_chg.done");

      // Real-time byte inside a message is transparent.
      send_byte(8'h90);
      send_byte(8'hF8);
      send_byte(8'h3C);
      send_byte(8'h64);
      pop_check("realtime", 8'h90, 7'h3C, 7'h64);
      expect_empty("realtime.done");

      // System common cancels a message in flight and the status.
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'hF0);
      send_byte(8'h64);
      send_byte(8'h00);
      expect_empty("sysex.discard");

      // Bad stop bit: byte dropped, sticky flag, data without status dropped.
      send_byte(8'h90, 1'b1);
      check("ferr.set", {31'd0, frame_err}, 32'd1);
      send_byte(8'h3C);
      send_byte(8'h64);
      expect_empty("ferr.no_event");
      check("ferr.sticky", {31'd0, frame_err}, 32'd1);
      clr_err = 1'b1;
      wait_clks(1);
      clr_err = 1'b0;
      check("ferr.clr", {31'd0, frame_err}, 32'd0);

      // Glitches on the line.
      midi_in = 1'b0;
      wait_clks(1);
      midi_in = 1'b1;
      wait_clks(100);
      midi_in = 1'b0;
      wait_clks(20);
      midi_in = 1'b1;
      wait_clks(100);
      expect_empty("glitch.no_event");
      check("glitch.ferr", {31'd0, frame_err}, 32'd0);
      check("glitch.ovf",  {31'd0, ovf}, 32'd0);
      send3(8'h80, 8'h3C, 8'h40);
      pop_check("glitch.after", 8'h80, 7'h3C, 7'h40);

      // Five note-ons into a four-deep FIFO.
      for (int i = 1; i <= 5; i++) begin
         logic [7:0] nn;
         logic [7:0] vv;
         nn = 8'(i);
         vv = 8'(8'h10 + i);
         send3(8'h90, nn, vv);
      end
      check("ovf.set", {31'd0, ovf}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         logic [6:0] nn;
         logic [6:0] vv;
         nn = 7'(i);
         vv = 7'(7'h10 + i);
         pop_check($sformatf("ovf.pop%0d", i), 8'h90, nn, vv);
      end
      expect_empty("ovf.drained");
      check("ovf.sticky", {31'd0, ovf}, 32'd1);

      // Reset in the middle of a frame, then a clean frame.
      midi_in = 1'b0;
      wait_clks(BIT_CLKS + 150);
      reset_n = 1'b0;
      midi_in = 1'b1;
      wait_clks(3);
      check("midreset.ovf",   {31'd0, ovf}, 32'd0);
      check("midreset.valid", {31'd0, ev_valid}, 32'd0);
      reset_n = 1'b1;
      wait_clks(100);
      send3(8'hB2, 8'h07, 8'h7F);
      pop_check("midreset.after", 8'hB2, 7'h07, 7'h7F);
      expect_empty("midreset.done");
      check("midreset.ferr", {31'd0, frame_err}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
